sdram_init: RTL and testbench

SDRAM_INIT -- requirements
Module: sdram_init

---
 rtl/sdram_init.sv | 186 ++++++++++++++++++
 tb/tb_sdram_init.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init.sv
// ---------------------------------------------------------------------------
// sdram_init
//
// Power-up initialisation sequencer for a single-data-rate SDRAM. After
// reset release it raises CKE, waits the power-up time with NOPs, precharges
// all banks, issues REF_NUM auto-refresh commands, loads the mode register
// and then flags init_done. The sequencer stays in DONE until the next reset.
// Every output comes straight from a flop.
//
// Ports
//   clk         in   system clock, also the SDRAM interface clock
//   rst_n       in   asynchronous active-low reset (synchronised system reset)
//   sdram_cke   out  SDRAM clock enable
//   sdram_cmd   out  {cs_n, ras_n, cas_n, we_n}
//   sdram_ba    out  bank address
//   sdram_addr  out  row / mode-register address
//   init_done   out  high once initialisation has completed (sticky)
// ---------------------------------------------------------------------------
module sdram_init #(
    parameter int unsigned T_PWRUP  = 20000,   // 1..65535
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_RFC    = 7,
    parameter int unsigned T_MRD    = 2,
    parameter int unsigned REF_NUM  = 8,       // 1..15
    parameter logic [11:0] MODE_REG = 12'h033
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic        init_done
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // Last value of the wait counter inside each wait state. A zero wait
    // parameter bypasses its state entirely, so the clamp only keeps the
    // constant in range.
    localparam logic [15:0] PWRUP_LAST = 16'(T_PWRUP - 1);
    localparam logic [15:0] RP_LAST    = (T_RP  == 0) ? 16'd0 : 16'(T_RP  - 1);
    localparam logic [15:0] RFC_LAST   = (T_RFC == 0) ? 16'd0 : 16'(T_RFC - 1);
    localparam logic [15:0] MRD_LAST   = (T_MRD == 0) ? 16'd0 : 16'(T_MRD - 1);
    localparam logic [3:0]  REF_TOTAL  = 4'(REF_NUM);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PRE,
        ST_TRP,
        ST_AREF,
        ST_TRFC,
        ST_MRS,
        ST_TMRD,
        ST_DONE
    } state_e;

    state_e      state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [3:0]  ref_q,    ref_d;
    logic        cke_q,    cke_d;
    logic [3:0]  cmd_q,    cmd_d;
    logic [1:0]  ba_q,     ba_d;
    logic [11:0] addr_q,   addr_d;
    logic        done_q,   done_d;

    // Next state and next outputs. The registered outputs are decoded from
    // state_d so that the command on the pins always belongs to the state
    // held in state_q during the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;

        if (!cke_q) begin
            // First edge after reset: CKE rises and the first power-up NOP
            // cycle starts with the counter still at zero.
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (cnt_q == PWRUP_LAST) state_d = ST_PRE;
                    else                     cnt_d   = cnt_q + 16'd1;
                end
                ST_PRE: begin
                    state_d = (T_RP == 0) ? ST_AREF : ST_TRP;
                end
                ST_TRP: begin
                    if (cnt_q == RP_LAST) state_d = ST_AREF;
                    else                  cnt_d   = cnt_q + 16'd1;
                end
                ST_AREF: begin
                    // ref_q already includes the refresh issued this cycle.
                    if (T_RFC != 0)              state_d = ST_TRFC;
                    else if (ref_q < REF_TOTAL)  state_d = ST_AREF;
                    else                         state_d = ST_MRS;
                end
                ST_TRFC: begin
                    if (cnt_q == RFC_LAST)
                        state_d = (ref_q < REF_TOTAL) ? ST_AREF : ST_MRS;
                    else
                        cnt_d = cnt_q + 16'd1;
                end
                ST_MRS: begin
                    state_d = (T_MRD == 0) ? ST_DONE : ST_TMRD;
                end
                ST_TMRD: begin
                    if (cnt_q == MRD_LAST) state_d = ST_DONE;
                    else                   cnt_d   = cnt_q + 16'd1;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase

            if (state_d != state_q) cnt_d = '0;
            // Each cycle spent in AREF is one refresh command on the bus.
            if (state_d == ST_AREF) ref_d = ref_q + 4'd1;
        end

        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        ba_d   = 2'b00;
        addr_d = 12'h000;
        done_d = 1'b0;
        unique case (state_d)
            ST_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = 12'h400;      // A10 high: precharge all banks
            end
            ST_AREF: begin
                cmd_d  = CMD_AREF;
            end
            ST_MRS: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_d  = CMD_NOP;
            end
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= 2'b00;
            addr_q  <= 12'h000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign sdram_cke  = cke_q;
    assign sdram_cmd  = cmd_q;
    assign sdram_ba   = ba_q;
    assign sdram_addr = addr_q;
    assign init_done  = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// ---------------------------------------------------------------------------
// tb_sdram_init
//
// Directed bench for sdram_init. Three instances share one clock:
//   dut_a  default parameters (full 20070-cycle sequence, reset in DONE)
//   dut_b  reduced parameters (hand-written command trace)
//   dut_c  short power-up, default refresh timing (reset mid-refresh)
// Cycles are counted from the CKE rise; outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_sdram_init;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    logic        cke_a,  cke_b,  cke_c;
    logic [3:0]  cmd_a,  cmd_b,  cmd_c;
    logic [1:0]  ba_a,   ba_b,   ba_c;
    logic [11:0] addr_a, addr_b, addr_c;
    logic        done_a, done_b, done_c;

    sdram_init dut_a (
        .clk(clk), .rst_n(rst_a), .sdram_cke(cke_a), .sdram_cmd(cmd_a),
        .sdram_ba(ba_a), .sdram_addr(addr_a), .init_done(done_a)
    );

    sdram_init #(
        .T_PWRUP(5), .T_RP(1), .T_RFC(3), .T_MRD(1), .REF_NUM(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .sdram_cke(cke_b), .sdram_cmd(cmd_b),
        .sdram_ba(ba_b), .sdram_addr(addr_b), .init_done(done_b)
    );

    sdram_init #(
        .T_PWRUP(10)
    ) dut_c (
        .clk(clk), .rst_n(rst_c), .sdram_cke(cke_c), .sdram_cmd(cmd_c),
        .sdram_ba(ba_c), .sdram_addr(addr_c), .init_done(done_c)
    );

    // Observation mux: the trace tasks watch whichever instance sel picks.
    int          sel;
    logic        obs_cke;
    logic [3:0]  obs_cmd;
    logic [1:0]  obs_ba;
    logic [11:0] obs_addr;
    logic        obs_done;

    always_comb begin
        obs_cke  = cke_a;
        obs_cmd  = cmd_a;
        obs_ba   = ba_a;
        obs_addr = addr_a;
        obs_done = done_a;
        case (sel)
            1: begin
                obs_cke = cke_b; obs_cmd = cmd_b; obs_ba = ba_b;
                obs_addr = addr_b; obs_done = done_b;
            end
            2: begin
                obs_cke = cke_c; obs_cmd = cmd_c; obs_ba = ba_c;
                obs_addr = addr_c; obs_done = done_c;
            end
            default: ;
        endcase
    end

    int n_vec;
    int n_err;

    int          ev_cyc[$];
    logic [17:0] ev_word[$];   // {cmd, ba, addr}
    int          nop_bad;
    int          cke_bad;
    int          done_drop;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cke"},  32'(obs_cke),  32'd0);
        check({tag, " cmd"},  32'(obs_cmd),  32'(NOP));
        check({tag, " ba"},   32'(obs_ba),   32'd0);
        check({tag, " addr"}, 32'(obs_addr), 32'd0);
        check({tag, " done"}, 32'(obs_done), 32'd0);
    endtask

    // Records every non-NOP command with its cycle number, counts illegal
    // NOP address/bank values, CKE drops and init_done drops, and keeps
    // watching for a few cycles after init_done so late commands show up.
    task automatic run_trace(input int budget, output int done_cyc);
        int tail;
        tail      = 0;
        done_cyc  = -1;
        nop_bad   = 0;
        cke_bad   = 0;
        done_drop = 0;
        ev_cyc.delete();
        ev_word.delete();
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (obs_cke !== 1'b1) cke_bad++;
            if (obs_cmd !== NOP) begin
                ev_cyc.push_back(t);
                ev_word.push_back({obs_cmd, obs_ba, obs_addr});
            end else if (obs_addr !== 12'h000 || obs_ba !== 2'b00) begin
                nop_bad++;
            end
            if (done_cyc < 0 && obs_done === 1'b1) done_cyc = t;
            if (done_cyc >= 0) begin
                if (obs_done !== 1'b1) done_drop++;
                tail++;
                if (tail > 8) break;
            end
        end
    endtask

    // Compares the recorded trace with the timeline implied by the timing
    // parameters; exp_done is the separately hand-computed completion cycle.
    task automatic verify(input string tag, input int p, input int rp,
                          input int rfc, input int mrd, input int n,
                          input logic [11:0] mode, input int done_cyc,
                          input int exp_done);
        int          exp_cyc;
        logic [17:0] exp_word;
        check({tag, " init_done cycle"}, done_cyc, exp_done);
        check({tag, " init_done formula"}, done_cyc,
              p + 1 + rp + n * (1 + rfc) + 1 + mrd);
        check({tag, " command count"}, ev_cyc.size(), n + 2);
        check({tag, " nop addr/ba"}, nop_bad, 0);
        check({tag, " cke held"}, cke_bad, 0);
        check({tag, " init_done sticky"}, done_drop, 0);
        for (int i = 0; i < n + 2 && i < ev_cyc.size(); i++) begin
            if (i == 0) begin
                exp_cyc  = p;
                exp_word = {PRE, 2'b00, 12'h400};
            end else if (i <= n) begin
                exp_cyc  = p + 1 + rp + (i - 1) * (1 + rfc);
                exp_word = {AREF, 2'b00, 12'h000};
            end else begin
                exp_cyc  = p + 1 + rp + n * (1 + rfc);
                exp_word = {LMR, 2'b00, mode};
            end
            check($sformatf("%s cmd%0d cycle", tag, i), ev_cyc[i], exp_cyc);
            check($sformatf("%s cmd%0d word", tag, i), 32'(ev_word[i]),
                  32'(exp_word));
        end
    endtask

    initial begin
        int d;
        int nref;
        n_vec = 0;
        n_err = 0;
        sel   = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values on all instances while rst_n is held low.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_reset_outputs($sformatf("reset dut%0d", s));
        end

        // Reduced parameters: PRE@5 AREF@7 AREF@11 MRS@15 done@17.
        sel = 1;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("reduced cke before edge", 32'(obs_cke), 32'd0);
        run_trace(100, d);
        verify("reduced", 5, 1, 3, 1, 2, 12'h033, d, 17);
        if (ev_cyc.size() == 4) begin
            check("reduced PRE@5",   ev_cyc[0], 5);
            check("reduced AREF@7",  ev_cyc[1], 7);
            check("reduced AREF@11", ev_cyc[2], 11);
            check("reduced MRS@15",  ev_cyc[3], 15);
        end

        // Default parameters: full sequence, init_done at 20070.
        sel = 0;
        @(negedge clk);
        rst_a = 1'b1;
        run_trace(20200, d);
        verify("default", 20000, 2, 7, 2, 8, 12'h033, d, 20070);

        // Reset while in DONE: outputs drop before any clock edge.
        #2;
        rst_a = 1'b0;
        #1;
        check_reset_outputs("reset in DONE");
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        run_trace(20200, d);
        verify("default rerun", 20000, 2, 7, 2, 8, 12'h033, d, 20070);

        // Reset three cycles into the wait after the 4th auto refresh.
        sel  = 2;
        nref = 0;
        @(negedge clk);
        rst_c = 1'b1;
        for (int t = 0; t < 200 && nref < 4; t++) begin
            @(negedge clk);
            if (obs_cmd === AREF) nref++;
        end
        check("mid-refresh 4th AREF reached", nref, 4);
        repeat (3) @(negedge clk);
        #2;
        rst_c = 1'b0;
        #1;
        check_reset_outputs("reset mid-refresh");
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        run_trace(300, d);
        verify("after mid reset", 10, 2, 7, 2, 8, 12'h033, d, 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
